// File: rtl/pwm_audio_tx.sv
// pwm_audio_tx: playback output stage. Pulls unsigned PCM samples over a
// valid/ready handshake and plays each one as REPEAT periods of registered
// PWM. It also drives the amplifier enable.
module pwm_audio_tx #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned REPEAT     = 4
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  play_i,
    input  logic [DATA_WIDTH-1:0] sample_data_i,
    input  logic                  sample_valid_i,
    output logic                  sample_ready_o,
    output logic                  pwm_out_o,
    output logic                  amp_en_o,
    output logic                  underrun_o,
    output logic                  active_o
);

    localparam int unsigned REP_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [DATA_WIDTH-1:0] CNT_PRE  = DATA_WIDTH'((2 ** DATA_WIDTH) - 2);
    localparam logic [DATA_WIDTH-1:0] SILENCE  = DATA_WIDTH'(2 ** (DATA_WIDTH - 1));
    localparam logic [REP_W-1:0]      REP_LAST = REP_W'(REPEAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   pwm_cnt_q;
    logic [REP_W-1:0]        rep_cnt_q;
    logic [DATA_WIDTH-1:0]   duty_q;
    logic                    ready_q;
    logic                    pwm_q;
    logic                    amp_q;
    logic                    underrun_q;

    logic                    at_boundary;
    logic                    pre_boundary;
    logic                    xfer;

    // Window position decode: last cycle of a window, and the cycle just before it.
    assign at_boundary  = (state_q == PLAY) && (pwm_cnt_q == CNT_MAX) && (rep_cnt_q == REP_LAST);
    assign pre_boundary = (state_q == PLAY) && (pwm_cnt_q == CNT_PRE) && (rep_cnt_q == REP_LAST);

    // ready_q is registered one cycle ahead. The play level gates it so that
    // nothing is offered or accepted in a cycle where playback is stopping.
    assign sample_ready_o = ready_q & play_i;
    assign xfer           = sample_valid_i & sample_ready_o;

    assign pwm_out_o  = pwm_q;
    assign amp_en_o   = amp_q;
    assign active_o   = amp_q;
    assign underrun_o = underrun_q;

    // Control FSM, counters, duty latch and registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            pwm_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            duty_q     <= SILENCE;
            ready_q    <= 1'b0;
            pwm_q      <= 1'b0;
            amp_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            pwm_q      <= 1'b0;
            amp_q      <= 1'b0;
            underrun_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    pwm_cnt_q <= '0;
                    rep_cnt_q <= '0;
                    if (play_i) begin
                        state_q <= PRIME;
                        ready_q <= 1'b1;
                    end
                end
                PRIME: begin
                    pwm_cnt_q <= '0;
                    rep_cnt_q <= '0;
                    if (!play_i) begin
                        state_q <= IDLE;
                    end else if (xfer) begin
                        duty_q  <= sample_data_i;
                        state_q <= PLAY;
                        amp_q   <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (!play_i) begin
                        // Stop immediately; the partial window is dropped.
                        state_q   <= IDLE;
                        pwm_cnt_q <= '0;
                        rep_cnt_q <= '0;
                    end else begin
                        amp_q     <= 1'b1;
                        pwm_q     <= (pwm_cnt_q < duty_q);
                        pwm_cnt_q <= pwm_cnt_q + 1'b1;
                        ready_q   <= pre_boundary;
                        if (pwm_cnt_q == CNT_MAX) begin
                            rep_cnt_q <= (rep_cnt_q == REP_LAST) ? '0 : rep_cnt_q + 1'b1;
                        end
                        if (at_boundary) begin
                            if (xfer) begin
                                duty_q <= sample_data_i;
                            end else begin
                                duty_q     <= SILENCE;
                                underrun_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    pwm_cnt_q <= '0;
                    rep_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_audio_tx.sv
// Bench for pwm_audio_tx (W=8, REPEAT=4). Expected waveforms come from window
// arithmetic: clock k of a window (k>=1) shows pwm high iff (k-1) mod 256 < duty.
module tb_pwm_audio_tx;

    localparam int unsigned W      = 8;
    localparam int unsigned R      = 4;
    localparam int          PERIOD = 256;
    localparam int          WINDOW = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic         play;
    logic [W-1:0] sample_data;
    logic         sample_valid;
    logic         sample_ready;
    logic         pwm_out;
    logic         amp_en;
    logic         underrun;
    logic         active;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    longint last_rdy = -1;

    pwm_audio_tx #(.DATA_WIDTH(W), .REPEAT(R)) dut (
        .clock_i        (clock),
        .reset_i        (reset),
        .play_i         (play),
        .sample_data_i  (sample_data),
        .sample_valid_i (sample_valid),
        .sample_ready_o (sample_ready),
        .pwm_out_o      (pwm_out),
        .amp_en_o       (amp_en),
        .underrun_o     (underrun),
        .active_o       (active)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Plays one full window that started on the previous edge at duty 'duty'.
    // Garbage valid/data are driven outside the ready cycle. At the boundary
    // the next sample is offered (give=1), or it is withheld.
    task automatic run_window(input string name, input int duty, input bit give,
                              input logic [W-1:0] nxt);
        int highs, pwm_bad, rdy_bad, und_bad, amp_bad;
        logic exp_pwm;
        highs = 0; pwm_bad = 0; rdy_bad = 0; und_bad = 0; amp_bad = 0;
        for (int k = 1; k <= WINDOW; k++) begin
            step();
            exp_pwm = (((k - 1) % PERIOD) < duty);
            if (pwm_out !== exp_pwm) pwm_bad++;
            if (pwm_out === 1'b1) highs++;
            if (sample_ready !== (k == WINDOW - 1)) rdy_bad++;
            if (underrun !== ((k == WINDOW) && !give)) und_bad++;
            if (amp_en !== 1'b1 || active !== 1'b1) amp_bad++;
            if (k % PERIOD == 0) begin
                chk({name, " highs/period"}, highs, duty);
                highs = 0;
            end
            if (k == WINDOW - 1) begin
                if (sample_ready === 1'b1) begin
                    if (last_rdy >= 0) chk({name, " ready spacing"}, cyc - last_rdy, WINDOW);
                    last_rdy = cyc;
                end
                sample_valid = give;
                sample_data  = give ? nxt : W'($urandom);
            end else begin
                sample_valid = 1'($urandom);
                sample_data  = W'($urandom);
            end
        end
        chk({name, " pwm pattern errs"}, pwm_bad, 0);
        chk({name, " ready errs"}, rdy_bad, 0);
        chk({name, " underrun errs"}, und_bad, 0);
        chk({name, " amp/active errs"}, amp_bad, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, " ready"}, sample_ready, 0);
        chk({name, " pwm"}, pwm_out, 0);
        chk({name, " amp_en"}, amp_en, 0);
        chk({name, " underrun"}, underrun, 0);
        chk({name, " active"}, active, 0);
    endtask

    initial begin : main
        logic [W-1:0] r1, r2, s;
        int bad, off;
        reset = 1'b1; play = 1'b1; sample_valid = 1'b1; sample_data = 8'h55;
        repeat (3) step();
        chk_all_zero("reset");

        // PRIME held 50 cycles without valid.
        reset = 1'b0; sample_valid = 1'b0;
        step();
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (sample_ready !== 1'b1 || amp_en !== 1'b0 || active !== 1'b0) bad++;
            step();
        end
        chk("prime hold errs", bad, 0);
        sample_valid = 1'b1; sample_data = 8'h40;
        step();
        sample_valid = 1'b0;
        chk("play entry amp_en", amp_en, 1);
        chk("play entry active", active, 1);
        chk("play entry pwm", pwm_out, 0);
        chk("play entry ready", sample_ready, 0);
        chk("play entry underrun", underrun, 0);

        r1 = W'($urandom);
        run_window("w40", 'h40, 1'b1, 8'hC0);
        run_window("wC0", 'hC0, 1'b1, r1);
        run_window("wrand", int'(r1), 1'b0, 8'h00);
        run_window("silence", 128, 1'b1, 8'h00);
        run_window("w00", 0, 1'b1, 8'hFF);
        r2 = W'($urandom);
        run_window("wFF", 255, 1'b1, r2);

        // Drop play partway through a window.
        off = $urandom_range(100, 900);
        for (int i = 0; i < off; i++) begin
            sample_valid = 1'($urandom); sample_data = W'($urandom);
            step();
        end
        play = 1'b0;
        step();
        chk_all_zero("stop");
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            sample_valid = 1'($urandom); sample_data = W'($urandom);
            step();
            if (sample_ready !== 1'b0 || pwm_out !== 1'b0 || amp_en !== 1'b0 ||
                underrun !== 1'b0) bad++;
        end
        chk("idle quiet errs", bad, 0);

        // play dropped exactly at a window boundary.
        play = 1'b1; sample_valid = 1'b0;
        step();
        sample_valid = 1'b1; sample_data = W'($urandom);
        step();
        sample_valid = 1'b0;
        for (int i = 0; i < WINDOW - 1; i++) step();
        chk("boundary ready", sample_ready, 1);
        play = 1'b0; sample_valid = 1'b1;
        #1;
        chk("boundary ready gated", sample_ready, 0);
        step();
        sample_valid = 1'b0;
        chk("boundary stop underrun", underrun, 0);
        chk("boundary stop amp_en", amp_en, 0);
        chk("boundary stop pwm", pwm_out, 0);

        // Reset in the middle of PLAY.
        play = 1'b1;
        step();
        s = W'($urandom_range(1, 255));
        sample_valid = 1'b1; sample_data = s;
        step();
        sample_valid = 1'b0;
        chk("pre-reset active", active, 1);
        repeat ($urandom_range(10, 500)) step();
        reset = 1'b1;
        step();
        chk_all_zero("reset mid-play");
        reset = 1'b0; play = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            sample_valid = 1'($urandom);
            step();
            if (sample_ready !== 1'b0 || amp_en !== 1'b0 || pwm_out !== 1'b0) bad++;
        end
        chk("post-reset idle errs", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
